// File: rtl/switch_conditioner.sv
// Switch front end: 2-flop synchronisers, per-switch debouncers, edge pulses
// and insert address generation for the switch-driven computer.
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s1,
    input  logic       s2,
    input  logic       s3,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    input  logic       b4,
    input  logic       b5,
    input  logic       b6,
    input  logic       b7,
    input  logic       b8,
    output logic       reset_req,
    output logic       exec_pulse,
    output logic       insert_pulse,
    output logic [7:0] insert_data,
    output logic [5:0] insert_adrs,
    output logic [7:0] live_data
);

    localparam int NSW = 11;
    localparam int IDX_S1 = 10;
    localparam int IDX_S2 = 9;
    localparam int IDX_S3 = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NSW-1:0] raw;
    logic [NSW-1:0] sync1_q, sync2_q;
    logic [NSW-1:0] stable_q, stable_d;
    logic [NSW-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0] prev_q, prev_d;
    logic [5:0] addr_q, addr_d;

    logic       reset_req_q, reset_req_d;
    logic       exec_q, exec_d;
    logic       insert_q, insert_d;
    logic [7:0] insert_data_q, insert_data_d;
    logic [5:0] insert_adrs_q, insert_adrs_d;
    logic [7:0] live_q, live_d;

    logic suppress;
    logic exec_rise;
    logic insert_rise;

    // b1 lands in data bit 7, b8 in bit 0
    assign raw = {s1, s2, s3, b1, b2, b3, b4, b5, b6, b7, b8};

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NSW; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Reset switch wins both while held and on the edge it is accepted
    assign suppress    = stable_q[IDX_S1] | stable_d[IDX_S1];
    assign exec_rise   = stable_q[IDX_S2] & ~prev_q[1];
    assign insert_rise = stable_q[IDX_S3] & ~prev_q[0];

    always_comb begin
        prev_d        = stable_q[IDX_S2:IDX_S3];
        reset_req_d   = stable_q[IDX_S1];
        live_d        = stable_q[7:0];
        exec_d        = exec_rise & ~suppress;
        insert_d      = insert_rise & ~suppress;
        insert_data_d = insert_data_q;
        insert_adrs_d = insert_adrs_q;
        addr_d        = addr_q;
        if (suppress) begin
            addr_d = '0;
        end else if (insert_rise) begin
            insert_data_d = live_q;
            insert_adrs_d = addr_q;
            addr_d        = addr_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            cnt_q         <= '0;
            prev_q        <= '0;
            addr_q        <= '0;
            reset_req_q   <= 1'b0;
            exec_q        <= 1'b0;
            insert_q      <= 1'b0;
            insert_data_q <= '0;
            insert_adrs_q <= '0;
            live_q        <= '0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            cnt_q         <= cnt_d;
            prev_q        <= prev_d;
            addr_q        <= addr_d;
            reset_req_q   <= reset_req_d;
            exec_q        <= exec_d;
            insert_q      <= insert_d;
            insert_data_q <= insert_data_d;
            insert_adrs_q <= insert_adrs_d;
            live_q        <= live_d;
        end
    end

    assign reset_req    = reset_req_q;
    assign exec_pulse   = exec_q;
    assign insert_pulse = insert_q;
    assign insert_data  = insert_data_q;
    assign insert_adrs  = insert_adrs_q;
    assign live_data    = live_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed sequences, glitch table and
// randomized switching against a window-based reference model.
module tb_switch_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s1 = 1'b1, s2 = 1'b1, s3 = 1'b1;
    logic [7:0] bv = 8'hFF;
    logic       reset_req, exec_pulse, insert_pulse;
    logic [7:0] insert_data, live_data;
    logic [5:0] insert_adrs;

    always #5 clk = ~clk;

    switch_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .s1(s1), .s2(s2), .s3(s3),
        .b1(bv[7]), .b2(bv[6]), .b3(bv[5]), .b4(bv[4]),
        .b5(bv[3]), .b6(bv[2]), .b7(bv[1]), .b8(bv[0]),
        .reset_req(reset_req), .exec_pulse(exec_pulse),
        .insert_pulse(insert_pulse), .insert_data(insert_data),
        .insert_adrs(insert_adrs), .live_data(live_data)
    );

    int checks = 0;
    int fails  = 0;
    int cyc_n  = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a level is accepted once the last D synchronised
    // samples all disagree with the accepted level.
    bit [10:0] hist[$];
    bit [10:0] win[$];
    bit [10:0] m_stable;
    bit [1:0]  m_prev;
    bit        m_rr, m_exec, m_ins;
    bit [7:0]  m_idata, m_live;
    bit [5:0]  m_iadrs;
    int        m_addr;

    task automatic m_reset();
        hist.delete();
        win.delete();
        m_stable = '0; m_prev = '0;
        m_rr = 0; m_exec = 0; m_ins = 0;
        m_idata = '0; m_live = '0; m_iadrs = '0;
        m_addr = 0;
    endtask

    task automatic m_step();
        bit [10:0] sin, nst;
        bit sup, er, ir, all_diff;
        sin = (hist.size() >= 2) ? hist[hist.size()-2] : 11'd0;
        hist.push_back({s1, s2, s3, bv});
        if (hist.size() > 2) void'(hist.pop_front());
        win.push_back(sin);
        if (win.size() > D) void'(win.pop_front());
        nst = m_stable;
        if (win.size() == D) begin
            for (int i = 0; i < 11; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (win[j][i] == m_stable[i]) all_diff = 1'b0;
                if (all_diff) nst[i] = ~m_stable[i];
            end
        end
        sup = m_stable[10] | nst[10];
        er = m_stable[9] & ~m_prev[1];
        ir = m_stable[8] & ~m_prev[0];
        m_rr = m_stable[10];
        m_exec = er & ~sup;
        m_ins = ir & ~sup;
        if (m_ins) begin
            m_idata = m_live;
            m_iadrs = 6'(m_addr);
        end
        if (sup) m_addr = 0;
        else if (ir) m_addr = (m_addr + 1) % 64;
        m_live = m_stable[7:0];
        m_prev = m_stable[9:8];
        m_stable = nst;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    int       n_exec = 0, n_ins = 0;
    int       exec_cyc = -1, ins_cyc = -1;
    bit [7:0] last_data;
    bit [5:0] last_adrs;
    int       adrs_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en)
                chk("model", {7'd0, reset_req, exec_pulse, insert_pulse,
                              insert_data, insert_adrs, live_data},
                    {7'd0, m_rr, m_exec, m_ins, m_idata, m_iadrs, m_live});
            if (exec_pulse === 1'b1) begin
                n_exec++;
                exec_cyc = cyc_n;
            end
            if (insert_pulse === 1'b1) begin
                n_ins++;
                ins_cyc = cyc_n;
                last_data = insert_data;
                last_adrs = insert_adrs;
                adrs_q.push_back(int'(insert_adrs));
            end
        end
    end

    task automatic do_insert();
        s3 = 1'b1;
        cyc(8);
        s3 = 1'b0;
        cyc(8);
    endtask

    task automatic clear_addr();
        s1 = 1'b1;
        cyc(10);
        s1 = 1'b0;
        cyc(10);
    endtask

    typedef struct {
        int len;
        int exp_exec;
    } glitch_t;

    glitch_t gt[6];
    int c, e0, i0, hold;

    initial begin
        gt[0] = '{1, 0}; gt[1] = '{2, 0}; gt[2] = '{3, 0};
        gt[3] = '{4, 1}; gt[4] = '{5, 1}; gt[5] = '{8, 1};

        // reset with every switch high
        @(negedge clk);
        #1;
        chk("rst_reset_req", reset_req, 0);
        chk("rst_exec", exec_pulse, 0);
        chk("rst_insert", insert_pulse, 0);
        chk("rst_idata", insert_data, 0);
        chk("rst_iadrs", insert_adrs, 0);
        chk("rst_live", live_data, 0);
        mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc(D + 2);
        chk("rel_rr_early", reset_req, 0);
        cyc(1);
        chk("rel_rr", reset_req, 1);
        chk("rel_live", live_data, 8'hFF);
        cyc(5);
        chk("rel_no_exec", n_exec, 0);
        chk("rel_no_ins", n_ins, 0);

        // clean insert
        s1 = 0; s2 = 0; s3 = 0; bv = 8'hA5;
        cyc(20);
        n_ins = 0;
        s3 = 1'b1;
        c = cyc_n;
        cyc(20);
        chk("ins1_count", n_ins, 1);
        chk("ins1_latency", ins_cyc, c + D + 3);
        chk("ins1_data", last_data, 8'hA5);
        chk("ins1_adrs", last_adrs, 0);
        s3 = 1'b0;
        cyc(10);
        s3 = 1'b1;
        cyc(10);
        chk("ins2_count", n_ins, 2);
        chk("ins2_adrs", last_adrs, 1);
        s3 = 1'b0;
        cyc(10);

        // glitch rejection table
        for (int i = 0; i < 6; i++) begin
            e0 = n_exec;
            s2 = 1'b1;
            cyc(gt[i].len);
            s2 = 1'b0;
            cyc(14);
            chk($sformatf("glitch_len%0d", gt[i].len), n_exec - e0,
                gt[i].exp_exec);
        end

        // wrap-around
        clear_addr();
        adrs_q.delete();
        repeat (65) do_insert();
        chk("wrap_count", adrs_q.size(), 65);
        for (int i = 0; i < 64; i++)
            if (i < adrs_q.size())
                chk($sformatf("wrap_adrs%0d", i), adrs_q[i], i);
        if (adrs_q.size() > 64) chk("wrap_65th", adrs_q[64], 0);

        // reset priority
        clear_addr();
        repeat (5) do_insert();
        chk("prio_pre_adrs", last_adrs, 4);
        e0 = n_exec;
        i0 = n_ins;
        s1 = 1; s2 = 1; s3 = 1;
        cyc(12);
        chk("prio_rr", reset_req, 1);
        chk("prio_no_exec", n_exec - e0, 0);
        chk("prio_no_ins", n_ins - i0, 0);
        s1 = 0; s2 = 0; s3 = 0;
        cyc(12);
        chk("prio_rr_low", reset_req, 0);
        do_insert();
        chk("prio_post_adrs", last_adrs, 0);

        // simultaneous execute and insert
        e0 = n_exec;
        i0 = n_ins;
        s2 = 1; s3 = 1;
        cyc(12);
        chk("sim_exec", n_exec - e0, 1);
        chk("sim_ins", n_ins - i0, 1);
        chk("sim_same_cycle", exec_cyc, ins_cyc);
        s2 = 0; s3 = 0;
        cyc(10);

        // randomized switching, occasional reset mid-debounce
        for (int i = 0; i < 300; i++) begin
            s1 = ($urandom_range(0, 9) == 0);
            s2 = 1'($urandom_range(0, 1));
            s3 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) bv = 8'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end
            hold = $urandom_range(1, 7);
            cyc(hold);
        end
        cyc(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Front-end input stage for the switch-driven computer. It synchronises and debounces the three toggle switches (s1 reset, s2 execute, s3 insert) and the eight binary data switches (b1..b8). It delivers to the top-level FSM a clean reset level, single-cycle execute and insert pulses, and a captured data byte with its program-memory address. It replaces the ad-hoc shift-register switch sampling in the top-level controller and sits directly upstream of it.

## Interface
- DEBOUNCE_CYCLES, default 50000: consecutive differing synchronised samples required to accept a new switch level (D below); legal range 2..65535.
- CNT_W, default 16: width of each debounce counter; must hold D-1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; one clock; asynchronous and active-high.
- s1, s2, s3  in  1 each  raw toggle switches: reset, execute, insert.
- b1..b8  in  1 each  raw binary switches; b1 is data bit 7, b8 is data bit 0.
- reset_req  out  1  debounced s1 level, registered.
- exec_pulse  out  1  one-cycle pulse on an accepted rising edge of s2.
- insert_pulse  out  1  one-cycle pulse on an accepted rising edge of s3.
- insert_data  out  8  debounced binary byte captured with insert_pulse.
- insert_adrs  out  6  program address for this insert (0..63).
- live_data  out  8  current debounced binary byte (for display).

## Operation
- Every one of the 11 inputs passes through a 2-flop synchroniser, then its own debouncer: a stable register and a CNT_W counter.
- Debouncer, per edge:
  - synced == stable: counter <= 0.
  - synced != stable and counter < D-1: counter <= counter+1.
  - synced != stable and counter == D-1: stable <= synced, counter <= 0.
  - A level is accepted only after D consecutive differing samples; any matching sample restarts the count.
- Edge detection: a registered previous-stable copy per toggle. Rising edge = stable & ~prev.
- Falling edges of s2 and s3 produce nothing.
- reset_req <= stable s1.
- While stable s1 is 1, or on the edge it becomes 1:
  - exec_pulse and insert_pulse are forced 0.
  - s2/s3 rising edges are discarded, not deferred.
  - The insert address counter is cleared to 0.
- Insert, on an accepted s3 rising edge:
  - insert_pulse <= 1.
  - insert_data <= live_data.
  - insert_adrs <= addr counter.
  - addr counter <= addr counter+1, modulo 64 (63 wraps to 0).
- insert_data and insert_adrs hold until the next insert or reset.
- Simultaneous s2 and s3 accepted edges: both pulses assert in the same cycle. The conditioner does no arbitration.
- live_data = the 8 stable bits, registered.

## Timing
- rst asserted clears immediately: all synchronisers, stable, prev, counters, addr counter and every output go to 0.
- Release of rst has no further effect; operation starts on the next rising edge.
- Latency: a level first sampled at edge k is in the synchroniser output after edge k+1 and is accepted (stable) at edge k+D+1. reset_req, exec_pulse, insert_pulse and live_data change at edge k+D+2.
- Pulses are exactly one clk cycle wide regardless of how long the switch is held.
- A switch held at 1 through reset release is treated as a new rising edge. It produces its pulse or level D+3 edges after the first post-release edge, subject to the s1 suppression rule.
- A glitch of D-1 or fewer synchronised cycles never changes any output.
- Bounce (toggling faster than D cycles) indefinitely delays acceptance; no pulse is emitted until the input has been stable for D samples.
- rst mid-debounce discards the partial count; no pulse is emitted for the interrupted edge.

## Test plan
All with D=4.
- Reset values: assert rst with all switches 1 -> all outputs 0 immediately. Release -> reset_req=1 and live_data=8'hFF after D+3 edges; exec_pulse/insert_pulse stay 0.
- Clean insert: s1=0, b1..b8 = 8'hA5, s3 rises and is held 20 cycles -> exactly one insert_pulse, 6 edges after sampling, with insert_data=8'hA5 and insert_adrs=0. A second insert gives insert_adrs=1.
- Glitch rejection: s2 high for 3 synchronised cycles, then low -> no exec_pulse. High for 4 cycles -> exactly one exec_pulse.
- Wrap-around: 64 inserts -> insert_adrs 0..63. The 65th insert -> insert_adrs=0.
- Reset priority: after 5 inserts, raise s1 together with s2 and s3 -> reset_req=1 with no pulses. Lower s1, then insert -> insert_adrs=0.
- Simultaneous: s2 and s3 rise on the same cycle -> exec_pulse and insert_pulse asserted in the same single cycle.
